// File: rtl/spi_slave_sclk.sv
// SPI mode-0 slave endpoint clocked entirely by SCLK: deserialises MOSI into
// frames, serialises tx_data_i onto MISO and counts frames per transaction.
module spi_slave_sclk #(
  parameter int F_SIZE    = 8,
  parameter int F_NUM     = 1,
  parameter int LSB_FIRST = 0,
  parameter int C_SIZE    = $clog2(F_SIZE),
  parameter int FC_SIZE   = $clog2(F_NUM) + 1
) (
  input  logic               SCLK,
  input  logic               rst,
  input  logic               CS,
  input  logic               MOSI,
  output logic               MISO,
  input  logic [F_SIZE-1:0]  tx_data_i,
  output logic [F_SIZE-1:0]  rx_data_o,
  output logic               rx_valid_o,
  output logic               busy_o,
  output logic [FC_SIZE-1:0] f_cnt_o,
  output logic               frame_done_o
);

  localparam logic [C_SIZE-1:0]  BIT_LAST   = C_SIZE'(F_SIZE - 1);
  localparam logic [FC_SIZE-1:0] FRAME_LAST = FC_SIZE'(F_NUM - 1);

  logic [C_SIZE-1:0] bit_cnt_r;
  logic [F_SIZE-1:0] rx_shift_r;
  logic [F_SIZE-1:0] tx_hold_r;
  logic              miso_q_r;

  logic [F_SIZE-1:0] rx_next_s;
  logic [F_SIZE-1:0] tx_load_s;
  logic [F_SIZE-1:0] tx_shift_s;
  logic              tx_first_s;
  logic              tx_out_s;
  logic              bit_zero_s;
  logic              last_bit_s;

  assign bit_zero_s = (bit_cnt_r == {C_SIZE{1'b0}});
  assign last_bit_s = (bit_cnt_r == BIT_LAST);
  assign busy_o     = ~bit_zero_s;

  // Bit-order dependent shift paths; the "output end" of tx_hold is MSB or LSB.
  always_comb begin
    rx_next_s  = {F_SIZE{1'b0}};
    tx_load_s  = {F_SIZE{1'b0}};
    tx_shift_s = {F_SIZE{1'b0}};
    tx_first_s = 1'b0;
    tx_out_s   = 1'b0;
    if (LSB_FIRST != 0) begin
      rx_next_s  = {MOSI, rx_shift_r[F_SIZE-1:1]};
      tx_load_s  = {1'b0, tx_data_i[F_SIZE-1:1]};
      tx_shift_s = {1'b0, tx_hold_r[F_SIZE-1:1]};
      tx_first_s = tx_data_i[0];
      tx_out_s   = tx_hold_r[0];
    end else begin
      rx_next_s  = {rx_shift_r[F_SIZE-2:0], MOSI};
      tx_load_s  = {tx_data_i[F_SIZE-2:0], 1'b0};
      tx_shift_s = {tx_hold_r[F_SIZE-2:0], 1'b0};
      tx_first_s = tx_data_i[F_SIZE-1];
      tx_out_s   = tx_hold_r[F_SIZE-1];
    end
  end

  // Frame-local state; CS high aborts the frame asynchronously.
  always_ff @(posedge SCLK or posedge rst or posedge CS) begin
    if (rst || CS) begin
      bit_cnt_r  <= {C_SIZE{1'b0}};
      rx_shift_r <= {F_SIZE{1'b0}};
      tx_hold_r  <= {F_SIZE{1'b0}};
    end else begin
      bit_cnt_r  <= last_bit_s ? {C_SIZE{1'b0}} : bit_cnt_r + C_SIZE'(1);
      rx_shift_r <= rx_next_s;
      tx_hold_r  <= bit_zero_s ? tx_load_s : tx_shift_s;
    end
  end

  // Completed-frame results survive an abort; only rst clears them.
  always_ff @(posedge SCLK or posedge rst) begin
    if (rst) begin
      rx_data_o    <= {F_SIZE{1'b0}};
      rx_valid_o   <= 1'b0;
      f_cnt_o      <= {FC_SIZE{1'b0}};
      frame_done_o <= 1'b0;
    end else if (!CS) begin
      if (last_bit_s) begin
        rx_data_o    <= rx_next_s;
        rx_valid_o   <= 1'b1;
        f_cnt_o      <= (f_cnt_o == FRAME_LAST) ? {FC_SIZE{1'b0}} : f_cnt_o + FC_SIZE'(1);
        frame_done_o <= (f_cnt_o == FRAME_LAST);
      end else begin
        rx_valid_o   <= 1'b0;
        frame_done_o <= 1'b0;
      end
    end
  end

  // Falling-edge launch keeps MISO stable at the master's rising-edge sample.
  always_ff @(negedge SCLK or posedge rst) begin
    if (rst) begin
      miso_q_r <= 1'b0;
    end else if (!CS) begin
      miso_q_r <= tx_out_s;
    end
  end

  // Bit 0 bypasses the register so back-to-back frames need no idle cycle.
  always_comb begin
    MISO = 1'b0;
    if (CS) begin
      MISO = 1'b0;
    end else if (bit_zero_s) begin
      MISO = tx_first_s;
    end else begin
      MISO = miso_q_r;
    end
  end

endmodule

// File: tb/tb_spi_slave_sclk.sv
// Directed bench for spi_slave_sclk: three instances cover F_NUM=3, F_NUM=1
// and LSB-first configurations, sharing SCLK/MOSI/tx data with separate CS.
module tb_spi_slave_sclk;

  logic       SCLK;
  logic       rst;
  logic       MOSI;
  logic [7:0] tx_data;
  logic       cs_a, cs_b, cs_c;

  logic       miso_a, miso_b, miso_c;
  logic [7:0] rx_a, rx_b, rx_c;
  logic       val_a, val_b, val_c;
  logic       busy_a, busy_b, busy_c;
  logic [2:0] fc_a;
  logic [0:0] fc_b, fc_c;
  logic       fd_a, fd_b, fd_c;

  int checks   = 0;
  int failures = 0;

  spi_slave_sclk #(.F_SIZE(8), .F_NUM(3), .LSB_FIRST(0)) dut_a (
    .SCLK(SCLK), .rst(rst), .CS(cs_a), .MOSI(MOSI), .MISO(miso_a),
    .tx_data_i(tx_data), .rx_data_o(rx_a), .rx_valid_o(val_a),
    .busy_o(busy_a), .f_cnt_o(fc_a), .frame_done_o(fd_a)
  );

  spi_slave_sclk #(.F_SIZE(8), .F_NUM(1), .LSB_FIRST(0)) dut_b (
    .SCLK(SCLK), .rst(rst), .CS(cs_b), .MOSI(MOSI), .MISO(miso_b),
    .tx_data_i(tx_data), .rx_data_o(rx_b), .rx_valid_o(val_b),
    .busy_o(busy_b), .f_cnt_o(fc_b), .frame_done_o(fd_b)
  );

  spi_slave_sclk #(.F_SIZE(8), .F_NUM(1), .LSB_FIRST(1)) dut_c (
    .SCLK(SCLK), .rst(rst), .CS(cs_c), .MOSI(MOSI), .MISO(miso_c),
    .tx_data_i(tx_data), .rx_data_o(rx_c), .rx_valid_o(val_c),
    .busy_o(busy_c), .f_cnt_o(fc_c), .frame_done_o(fd_c)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // One mode-0 bit: MOSI set and MISO sampled while SCLK is low, then a full pulse.
  task automatic send_bit(input int sel, input logic b, output logic m);
    MOSI = b;
    #4;
    case (sel)
      0:       m = miso_a;
      1:       m = miso_b;
      default: m = miso_c;
    endcase
    #1 SCLK = 1'b1;
    #5 SCLK = 1'b0;
  endtask

  // Full frame; MISO bits are reassembled into a word in the same bit order.
  task automatic send_frame(input int sel, input logic [7:0] tx, input logic [7:0] w,
                            input logic lsb, output logic [7:0] got);
    logic bt;
    tx_data = tx;
    got = 8'h00;
    for (int i = 0; i < 8; i++) begin
      int idx;
      idx = lsb ? i : 7 - i;
      send_bit(sel, w[idx], bt);
      got[idx] = bt;
    end
    #1;
  endtask

  logic [7:0] got;
  logic       bt;
  logic [7:0] word_tab [3];
  logic [7:0] tx_tab   [3];
  logic [2:0] fc_tab   [3];

  initial begin
    SCLK = 1'b0; rst = 1'b1; MOSI = 1'b0; tx_data = 8'h00;
    cs_a = 1'b1; cs_b = 1'b1; cs_c = 1'b1;
    word_tab = '{8'h11, 8'h22, 8'h33};
    tx_tab   = '{8'hC3, 8'h96, 8'h0F};
    fc_tab   = '{3'd1, 3'd2, 3'd0};
    #10;
    check_eq("rst_rx", {24'h0, rx_a}, 32'h0);
    check_eq("rst_valid", {31'h0, val_a}, 32'h0);
    check_eq("rst_fcnt", {29'h0, fc_a}, 32'h0);
    check_eq("rst_miso", {31'h0, miso_a}, 32'h0);
    rst = 1'b0;
    #10;

    // Reset mid-frame, then a clean frame on the F_NUM=1 instance.
    cs_b = 1'b0;
    tx_data = 8'h5A;
    send_bit(1, 1'b1, bt);
    send_bit(1, 1'b0, bt);
    send_bit(1, 1'b1, bt);
    #1;
    check_eq("mid_busy", {31'h0, busy_b}, 32'h1);
    rst = 1'b1;
    #1;
    check_eq("rstmid_busy", {31'h0, busy_b}, 32'h0);
    check_eq("rstmid_rx", {24'h0, rx_b}, 32'h0);
    check_eq("rstmid_valid", {31'h0, val_b}, 32'h0);
    check_eq("rstmid_done", {31'h0, fd_b}, 32'h0);
    check_eq("rstmid_miso", {31'h0, miso_b}, 32'h0);
    #4 rst = 1'b0;
    #5;
    send_frame(1, 8'h5A, 8'h3C, 1'b0, got);
    check_eq("after_rst_rx", {24'h0, rx_b}, 32'h3C);
    check_eq("after_rst_miso", {24'h0, got}, 32'h5A);

    // Single frame, F_NUM=1.
    send_frame(1, 8'h5A, 8'hA5, 1'b0, got);
    check_eq("single_rx", {24'h0, rx_b}, 32'hA5);
    check_eq("single_miso", {24'h0, got}, 32'h5A);
    check_eq("single_valid", {31'h0, val_b}, 32'h1);
    check_eq("single_done", {31'h0, fd_b}, 32'h1);
    check_eq("single_fcnt", {31'h0, fc_b}, 32'h0);
    cs_b = 1'b1;
    #10;

    // Back-to-back frames, F_NUM=3.
    cs_a = 1'b0;
    for (int f = 0; f < 3; f++) begin
      send_frame(0, tx_tab[f], word_tab[f], 1'b0, got);
      check_eq("b2b_rx", {24'h0, rx_a}, {24'h0, word_tab[f]});
      check_eq("b2b_miso", {24'h0, got}, {24'h0, tx_tab[f]});
      check_eq("b2b_valid", {31'h0, val_a}, 32'h1);
      check_eq("b2b_fcnt", {29'h0, fc_a}, {29'h0, fc_tab[f]});
      check_eq("b2b_done", {31'h0, fd_a}, (f == 2) ? 32'h1 : 32'h0);
    end
    cs_a = 1'b1;
    #10;

    // Abort after 5 bits, then a full frame.
    cs_a = 1'b0;
    tx_data = 8'h00;
    for (int i = 0; i < 5; i++) send_bit(0, 1'b1, bt);
    #1;
    check_eq("abort_valid", {31'h0, val_a}, 32'h0);
    check_eq("abort_busy", {31'h0, busy_a}, 32'h1);
    cs_a = 1'b1;
    #2;
    check_eq("abort_busy_clr", {31'h0, busy_a}, 32'h0);
    check_eq("abort_miso", {31'h0, miso_a}, 32'h0);
    check_eq("abort_rx_kept", {24'h0, rx_a}, 32'h33);
    cs_a = 1'b0;
    #2;
    send_frame(0, 8'h00, 8'h81, 1'b0, got);
    check_eq("abort_rx", {24'h0, rx_a}, 32'h81);
    check_eq("abort_fcnt", {29'h0, fc_a}, 32'h1);
    check_eq("abort_done", {31'h0, fd_a}, 32'h0);
    cs_a = 1'b1;
    #10;

    // LSB-first instance.
    cs_c = 1'b0;
    send_frame(2, 8'h80, 8'h01, 1'b1, got);
    check_eq("lsb_rx", {24'h0, rx_c}, 32'h01);
    check_eq("lsb_miso", {24'h0, got}, 32'h80);
    check_eq("lsb_valid", {31'h0, val_c}, 32'h1);
    cs_c = 1'b1;
    #10;

    // SCLK toggling with every CS high must change nothing.
    tx_data = 8'hFF;
    for (int i = 0; i < 4; i++) send_bit(1, 1'b1, bt);
    #1;
    check_eq("idle_miso", {31'h0, miso_b}, 32'h0);
    check_eq("idle_busy", {31'h0, busy_b}, 32'h0);
    check_eq("idle_rx", {24'h0, rx_b}, 32'hA5);
    check_eq("idle_valid", {31'h0, val_b}, 32'h1);
    check_eq("idle_fcnt", {29'h0, fc_a}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
